if_fetch_stage: RTL

//  Instruction-fetch stage: owns the PC and the IF/ID pipeline register, and fetches from

---
 rtl/if_fetch_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID pipeline register and a req/ack imem fetch FSM
// with hold buffer for stalled acks and a drain state for branches with a request in flight.
module if_fetch_stage #(
  parameter int unsigned                ADDR_WIDTH  = 32,
  parameter int unsigned                INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pcWrite,
  input  logic                   ifIdWrite,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchTarget,
  output logic                   imemReq,
  output logic [ADDR_WIDTH-1:0]  imemAddr,
  input  logic                   imemAck,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic [INSTR_WIDTH-1:0] ifIdInstr,
  output logic [ADDR_WIDTH-1:0]  ifIdPcPlus4,
  output logic                   ifIdValid,
  output logic                   fetchStall
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [INSTR_WIDTH-1:0] holdBuf;
  logic [ADDR_WIDTH-1:0]  pcPlus4;
  logic [ADDR_WIDTH-1:0]  target;
  logic                   unusedTgtLsbs;

  assign pcPlus4       = pc + ADDR_WIDTH'(4);
  assign target        = {branchTarget[ADDR_WIDTH-1:2], 2'b00};
  assign unusedTgtLsbs = ^branchTarget[1:0];

  always_comb begin
    fetchStall = 1'b0;
    if (state == FETCH && !imemAck && ifIdWrite)
      fetchStall = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imemReq     <= 1'b0;
      imemAddr    <= RESET_PC;
      ifIdInstr   <= NOP_INSTR;
      ifIdPcPlus4 <= '0;
      ifIdValid   <= 1'b0;
      holdBuf     <= NOP_INSTR;
    end else if (branchTaken) begin
      pc        <= target;
      ifIdInstr <= NOP_INSTR;
      ifIdValid <= 1'b0;
      unique case (state)
        // An in-flight request cannot be aborted: let it complete in DRAIN and drop its data.
        FETCH: begin
          if (imemAck) begin
            imemAddr <= target;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: state <= DRAIN;
        default: begin
          state    <= FETCH;
          imemReq  <= 1'b1;
          imemAddr <= target;
        end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          imemReq <= 1'b1;
          state   <= FETCH;
        end
        FETCH: begin
          if (imemAck) begin
            if (ifIdWrite) begin
              ifIdInstr   <= imemData;
              ifIdPcPlus4 <= pcPlus4;
              ifIdValid   <= 1'b1;
              if (pcWrite) begin
                pc       <= pcPlus4;
                imemAddr <= pcPlus4;
              end
            end else begin
              holdBuf <= imemData;
              imemReq <= 1'b0;
              state   <= HOLD;
            end
          end else if (ifIdWrite) begin
            ifIdInstr <= NOP_INSTR;
            ifIdValid <= 1'b0;
          end
        end
        // Once the buffered word is consumed, always refetch; PC advances only if allowed.
        HOLD: begin
          if (ifIdWrite) begin
            ifIdInstr   <= holdBuf;
            ifIdPcPlus4 <= pcPlus4;
            ifIdValid   <= 1'b1;
            imemReq     <= 1'b1;
            state       <= FETCH;
            if (pcWrite) begin
              pc       <= pcPlus4;
              imemAddr <= pcPlus4;
            end
          end
        end
        DRAIN: begin
          if (ifIdWrite) begin
            ifIdInstr <= NOP_INSTR;
            ifIdValid <= 1'b0;
          end
          if (imemAck) begin
            imemAddr <= pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
